// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: one data-bus transaction per load/store
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   mem_aluop .. mem_wdata        instruction fields from the EX/MEM register
//   exc_code_i                    exception code carried in from upstream stages
//   flush, wb_hold                pipeline flush, downstream (MEM/WB) hold
//   dbus_req/we/be/addr/wdata     registered data-bus request
//   dbus_ack, dbus_rdata          bus completion and read data (valid with ack)
//   wb_wd, wb_wreg, wb_wdata      result toward MEM/WB
//   exc_code_o, badvaddr_o        resolved exception and faulting address
//   stallreq                      holds the pipeline while a transaction is in flight
module mem_access_stage #(
  parameter int               EXC_W   = 5,
  parameter logic [EXC_W-1:0] EC_NONE = EXC_W'(5'h00),
  parameter logic [EXC_W-1:0] EC_ADEL = EXC_W'(5'h04),
  parameter logic [EXC_W-1:0] EC_ADES = EXC_W'(5'h05),
  parameter logic [7:0]       OP_LB   = 8'hE0,
  parameter logic [7:0]       OP_LBU  = 8'hE4,
  parameter logic [7:0]       OP_LH   = 8'hE1,
  parameter logic [7:0]       OP_LHU  = 8'hE5,
  parameter logic [7:0]       OP_LW   = 8'hE3,
  parameter logic [7:0]       OP_SB   = 8'hE8,
  parameter logic [7:0]       OP_SH   = 8'hE9,
  parameter logic [7:0]       OP_SW   = 8'hEB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       mem_aluop,
  input  logic [31:0]      mem_mem_addr,
  input  logic [31:0]      mem_reg2,
  input  logic [4:0]       mem_wd,
  input  logic             mem_wreg,
  input  logic [31:0]      mem_wdata,
  input  logic [EXC_W-1:0] exc_code_i,
  input  logic             flush,
  input  logic             wb_hold,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [3:0]       dbus_be,
  output logic [31:0]      dbus_addr,
  output logic [31:0]      dbus_wdata,
  input  logic             dbus_ack,
  input  logic [31:0]      dbus_rdata,
  output logic [4:0]       wb_wd,
  output logic             wb_wreg,
  output logic [31:0]      wb_wdata,
  output logic [EXC_W-1:0] exc_code_o,
  output logic [31:0]      badvaddr_o,
  output logic             stallreq
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] rdata_q;
  logic [7:0]  op_q;      // load op of the transaction in flight, for extraction in DONE
  logic [1:0]  lo_q;      // byte offset of the transaction in flight

  logic        is_load, is_store, is_mem, is_half, is_word;
  logic        misaligned, acc_valid;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode and access qualification
  always_comb begin
    is_load    = mem_aluop inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_store   = mem_aluop inside {OP_SB, OP_SH, OP_SW};
    is_mem     = is_load | is_store;
    is_half    = mem_aluop inside {OP_LH, OP_LHU, OP_SH};
    is_word    = mem_aluop inside {OP_LW, OP_SW};
    misaligned = is_mem & ((is_half & mem_mem_addr[0]) |
                           (is_word & (mem_mem_addr[1:0] != 2'b00)));
    acc_valid  = is_mem & (exc_code_i == EC_NONE) & ~misaligned & ~flush;
  end

  // Store lane steering; loads always read the full word
  always_comb begin
    be_c = 4'hF;
    wd_c = 32'h0;
    if (mem_aluop == OP_SB) begin
      be_c = 4'b0001 << mem_mem_addr[1:0];
      wd_c = {4{mem_reg2[7:0]}};
    end else if (mem_aluop == OP_SH) begin
      be_c = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
      wd_c = {2{mem_reg2[15:0]}};
    end else if (mem_aluop == OP_SW) begin
      wd_c = mem_reg2;
    end
  end

  // Load extraction from the captured word (little-endian lanes)
  always_comb begin
    ld_byte = rdata_q[{lo_q, 3'b000} +: 8];
    ld_half = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stallreq = 1'b0;
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    case (state)
      S_IDLE: begin
        if (acc_valid) begin
          stallreq = 1'b1;
          wb_wreg  = 1'b0;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        // A flush coinciding with ack still completes the bus cycle; the data is dropped.
        if (dbus_ack)   state_nx = flush ? S_IDLE : S_DONE;
        else if (flush) state_nx = S_DRAIN;
      end
      S_DONE: begin
        wb_wdata = dbus_we ? mem_wdata : ld_ext;
        wb_wreg  = dbus_we ? 1'b0 : mem_wreg;
        if (!wb_hold) state_nx = S_IDLE;
      end
      S_DRAIN: begin
        // The orphaned request must finish before a new one may be launched.
        if (is_mem) begin
          stallreq = acc_valid;
          wb_wreg  = 1'b0;
        end
        if (dbus_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush || misaligned) wb_wreg = 1'b0;
    if (!rst) begin
      stallreq = 1'b0;
      wb_wreg  = 1'b0;
    end
  end

  always_comb begin
    exc_code_o = exc_code_i;
    badvaddr_o = 32'h0;
    if (!rst) begin
      exc_code_o = EC_NONE;
    end else if (misaligned) begin
      exc_code_o = is_load ? EC_ADEL : EC_ADES;
      badvaddr_o = mem_mem_addr;
    end
  end

  // Bus request registers: launched from IDLE, held stable until ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_be    <= 4'h0;
      dbus_addr  <= 32'h0;
      dbus_wdata <= 32'h0;
      rdata_q    <= 32'h0;
      op_q       <= 8'h0;
      lo_q       <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc_valid) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_be    <= be_c;
            dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
            dbus_wdata <= wd_c;
            op_q       <= mem_aluop;
            lo_q       <= mem_mem_addr[1:0];
          end
        end
        S_REQ: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            rdata_q  <= dbus_rdata;
          end
        end
        S_DRAIN: begin
          if (dbus_ack) dbus_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [4:0]  exc_code_i;
  logic        flush, wb_hold;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [4:0]  exc_code_o;
  logic [31:0] badvaddr_o;
  logic        stallreq;

  typedef struct packed {
    logic [31:0] wdata;
    logic        wreg;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .exc_code_i(exc_code_i), .flush(flush), .wb_hold(wb_hold),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .exc_code_o(exc_code_o), .badvaddr_o(badvaddr_o), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    mem_aluop    = OP_NOP;
    mem_mem_addr = 32'h0;
    mem_reg2     = 32'h0;
    mem_wreg     = 1'b0;
    exc_code_i   = 5'h00;
    flush        = 1'b0;
    wb_hold      = 1'b0;
    dbus_ack     = 1'b0;
    dbus_rdata   = 32'h0;
  endtask

  // Runs one load/store from IDLE; called just after a rising edge.
  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata,
                        input int ack_wait, input int hold, input logic [3:0] exp_be,
                        input logic [31:0] exp_bus_wdata, input logic [31:0] exp_wb,
                        input logic exp_wreg);
    int   stalls, reqs;
    bit   done;
    bit   is_st;
    exp_t e;
    is_st        = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wd       = 5'd7;
    mem_wreg     = 1'b1;
    mem_wdata    = 32'hAAAA5555;
    exc_code_i   = 5'h00;
    flush        = 1'b0;
    wb_hold      = 1'b0;
    dbus_ack     = 1'b0;
    sb_q.push_back('{wdata: exp_wb, wreg: exp_wreg});
    #1;
    chk({tag, "_idle_stall"}, 32'(stallreq), 32'h1);
    chk({tag, "_idle_req"}, 32'(dbus_req), 32'h0);
    stalls = 0;
    reqs   = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (dbus_req) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
          chk({tag, "_be"}, 32'(dbus_be), 32'(exp_be));
          chk({tag, "_we"}, 32'(dbus_we), 32'(is_st));
          if (is_st) chk({tag, "_bus_wdata"}, dbus_wdata, exp_bus_wdata);
        end
        if (reqs == ack_wait + 1) begin
          dbus_ack   = 1'b1;
          dbus_rdata = rdata;
        end
      end
      if (stallreq) stalls++;
      else if (c > 0) done = 1'b1;
      if (!done) begin
        @(posedge clk);
        #1;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        #1;
      end
    end
    chk({tag, "_completed"}, 32'(done), 32'h1);
    if (done) begin
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(ack_wait + 2));
      chk({tag, "_req_cycles"}, 32'(reqs), 32'(ack_wait + 1));
      chk({tag, "_done_req"}, 32'(dbus_req), 32'h0);
      chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'h1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_wb_wreg"}, 32'(wb_wreg), 32'(e.wreg));
        if (e.wreg) begin
          chk({tag, "_wb_wdata"}, wb_wdata, e.wdata);
          chk({tag, "_wb_wd"}, 32'(wb_wd), 32'd7);
        end
        wb_hold = (hold > 0);
        for (int h = 0; h < hold; h++) begin
          @(posedge clk);
          #1;
          if (h == hold - 1) wb_hold = 1'b0;
          #1;
          chk({tag, "_hold_stall"}, 32'(stallreq), 32'h0);
          chk({tag, "_hold_req"}, 32'(dbus_req), 32'h0);
          chk({tag, "_hold_wdata"}, wb_wdata, e.wdata);
        end
      end
    end
    @(posedge clk);
    #1;
    set_nop();
    #1;
  endtask

  task automatic exc_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [4:0] exp_exc);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = 32'h12345678;
    mem_wreg     = 1'b1;
    exc_code_i   = 5'h00;
    #1;
    chk({tag, "_exc"}, 32'(exc_code_o), 32'(exp_exc));
    chk({tag, "_badvaddr"}, badvaddr_o, addr);
    chk({tag, "_stall"}, 32'(stallreq), 32'h0);
    chk({tag, "_wreg"}, 32'(wb_wreg), 32'h0);
    @(posedge clk);
    #2;
    chk({tag, "_no_req"}, 32'(dbus_req), 32'h0);
    set_nop();
  endtask

  initial begin
    rst       = 1'b0;
    set_nop();
    mem_wd    = 5'd0;
    mem_wdata = 32'h0;
    // Reset with a valid-looking load on the inputs
    mem_aluop    = OP_LW;
    mem_mem_addr = 32'h100;
    mem_wreg     = 1'b1;
    #2;
    chk("rst_req", 32'(dbus_req), 32'h0);
    chk("rst_be", 32'(dbus_be), 32'h0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wdata, 32'h0);
    chk("rst_stall", 32'(stallreq), 32'h0);
    chk("rst_wreg", 32'(wb_wreg), 32'h0);
    chk("rst_exc", 32'(exc_code_o), 32'h0);
    set_nop();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    mem_op("lw_100",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1);
    mem_op("lb_103",  OP_LB,  32'h103, 32'h0, 32'h80112233, 0, 0, 4'hF, 32'h0, 32'hFFFFFF80, 1'b1);
    mem_op("lbu_103", OP_LBU, 32'h103, 32'h0, 32'h80112233, 0, 0, 4'hF, 32'h0, 32'h00000080, 1'b1);
    mem_op("lbu_101", OP_LBU, 32'h101, 32'h0, 32'h80112233, 0, 0, 4'hF, 32'h0, 32'h00000022, 1'b1);
    mem_op("lh_102",  OP_LH,  32'h102, 32'h0, 32'h80112233, 0, 0, 4'hF, 32'h0, 32'hFFFF8011, 1'b1);
    mem_op("lhu_100", OP_LHU, 32'h100, 32'h0, 32'h1234F00D, 2, 0, 4'hF, 32'h0, 32'h0000F00D, 1'b1);
    mem_op("sh_202",  OP_SH,  32'h202, 32'h1234ABCD, 32'h0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    mem_op("sb_201",  OP_SB,  32'h201, 32'h00000055, 32'h0, 1, 0, 4'b0010, 32'h55555555, 32'h0, 1'b0);
    mem_op("sw_204",  OP_SW,  32'h204, 32'hCAFEBABE, 32'h0, 0, 0, 4'hF, 32'hCAFEBABE, 32'h0, 1'b0);
    mem_op("lw_hold", OP_LW,  32'h208, 32'h0, 32'h01020304, 0, 2, 4'hF, 32'h0, 32'h01020304, 1'b1);

    exc_op("adel_lw", OP_LW, 32'h101, 5'h04);
    exc_op("ades_sw", OP_SW, 32'h102, 5'h05);
    exc_op("adel_lh", OP_LH, 32'h101, 5'h04);

    // Non-memory op passes through with upstream exception code
    mem_aluop  = 8'h21;
    exc_code_i = 5'h0C;
    mem_wd     = 5'd9;
    mem_wreg   = 1'b1;
    mem_wdata  = 32'hCAFEF00D;
    #1;
    chk("pass_exc", 32'(exc_code_o), 32'h0C);
    chk("pass_badv", badvaddr_o, 32'h0);
    chk("pass_wdata", wb_wdata, 32'hCAFEF00D);
    chk("pass_wd", 32'(wb_wd), 32'd9);
    chk("pass_wreg", 32'(wb_wreg), 32'h1);
    chk("pass_stall", 32'(stallreq), 32'h0);
    @(posedge clk);
    #1;
    set_nop();

    // Flush during REQ, ack three cycles later, new LW waiting behind it
    mem_aluop    = OP_LW;
    mem_mem_addr = 32'h300;
    mem_wreg     = 1'b1;
    #1;
    @(posedge clk);
    #2;
    chk("fl_req_up", 32'(dbus_req), 32'h1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    mem_mem_addr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fl_drain_req", 32'(dbus_req), 32'h1);
      chk("fl_drain_addr", dbus_addr, 32'h300);
      chk("fl_drain_stall", 32'(stallreq), 32'h1);
      chk("fl_drain_wreg", 32'(wb_wreg), 32'h0);
      if (k == 2) begin
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h0BAD0BAD;
      end
      @(posedge clk);
      #1;
    end
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    #1;
    chk("fl_after_ack_req", 32'(dbus_req), 32'h0);
    mem_op("fl_new_lw", OP_LW, 32'h400, 32'h0, 32'h11110000, 0, 0, 4'hF, 32'h0, 32'h11110000, 1'b1);

    // Asynchronous reset in the middle of a transaction
    mem_aluop    = OP_LW;
    mem_mem_addr = 32'h500;
    mem_wreg     = 1'b1;
    #1;
    @(posedge clk);
    #2;
    chk("ar_req_up", 32'(dbus_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("ar_req_drop", 32'(dbus_req), 32'h0);
    chk("ar_stall", 32'(stallreq), 32'h0);
    chk("ar_wreg", 32'(wb_wreg), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_nop();
    #1;
    chk("ar_release_req", 32'(dbus_req), 32'h0);
    mem_op("ar_lw_600", OP_LW, 32'h600, 32'h0, 32'h600D600D, 0, 0, 4'hF, 32'h0, 32'h600D600D, 1'b1);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
